// File: rtl/short_poly_gen.sv
// short_poly_gen: fills a coefficient RAM with a random ternary polynomial,
// either uniform small or fixed-weight short, from a private 32-bit LFSR.
module short_poly_gen #(
  parameter int P  = 757,
  parameter int W  = 286,
  parameter int Q  = 5167,
  parameter int DW = 13,
  parameter int AW = 11
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          start,
  input  logic          mode,
  input  logic [31:0]   seed,
  input  logic [DW-1:0] mem_rdata,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_wdata,
  output logic          mem_we,
  output logic          busy,
  output logic          done,
  output logic [AW-1:0] weight
);

  if (W > P) begin : g_bad_w
    $error("short_poly_gen: W must not exceed P");
  end
  if ((Q - 1) >= (1 << DW)) begin : g_bad_dw
    $error("short_poly_gen: Q-1 does not fit in DW bits");
  end
  if ((1 << AW) < P) begin : g_bad_aw
    $error("short_poly_gen: AW too narrow for P");
  end

  typedef enum logic [2:0] {
    S_IDLE,
    S_GEN,
    S_CLEAR,
    S_DRAW,
    S_CHECK,
    S_DONE
  } state_t;

  localparam logic [31:0]   TAPS = 32'h8020_0003;
  localparam logic [AW-1:0] LAST = AW'(P - 1);
  localparam logic [AW:0]   PLIM = (AW + 1)'(P);
  localparam logic [AW-1:0] WTGT = AW'(W);
  localparam logic [DW-1:0] POS  = DW'(1);
  localparam logic [DW-1:0] NEG  = DW'(Q - 1);

  state_t        state_q, state_d;
  logic [31:0]   lfsr_q, lfsr_d;
  logic [AW-1:0] i_q, i_d;
  logic [AW-1:0] r_q, r_d;
  logic          s_q, s_d;
  logic [AW-1:0] wt_q, wt_d;

  logic [31:0]   lfsr_adv;
  logic [AW-1:0] r_w;
  logic          s_w;
  logic [1:0]    t_w;
  logic          in_rng;
  logic          hit;

  assign lfsr_adv = {1'b0, lfsr_q[31:1]}
                  ^ (lfsr_q[0] ? TAPS : 32'h0);
  assign r_w      = lfsr_q[AW-1:0];
  assign s_w      = lfsr_q[AW];
  assign t_w      = lfsr_q[1:0];
  assign in_rng   = {1'b0, r_w} < PLIM;
  assign hit      = mem_rdata != '0;

  always_comb begin
    state_d   = state_q;
    lfsr_d    = lfsr_q;
    i_d       = i_q;
    r_d       = r_q;
    s_d       = s_q;
    wt_d      = wt_q;
    mem_addr  = '0;
    mem_wdata = '0;
    mem_we    = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (start) begin
          lfsr_d  = (seed == 32'h0) ? 32'h1 : seed;
          i_d     = '0;
          wt_d    = '0;
          state_d = mode ? S_CLEAR : S_GEN;
        end
      end
      S_GEN: begin
        lfsr_d = lfsr_adv;
        if (t_w != 2'b11) begin
          mem_we   = 1'b1;
          mem_addr = i_q;
          unique case (1'b1)
            (t_w == 2'b01): mem_wdata = POS;
            (t_w == 2'b10): mem_wdata = NEG;
            default:        mem_wdata = '0;
          endcase
          if (t_w != 2'b00) wt_d = wt_q + 1'b1;
          i_d = i_q + 1'b1;
          if (i_q == LAST) state_d = S_DONE;
        end
      end
      S_CLEAR: begin
        mem_we   = 1'b1;
        mem_addr = i_q;
        i_d      = i_q + 1'b1;
        if (i_q == LAST)
          state_d = (W == 0) ? S_DONE : S_DRAW;
      end
      S_DRAW: begin
        lfsr_d   = lfsr_adv;
        mem_addr = r_w;
        if (in_rng) begin
          r_d     = r_w;
          s_d     = s_w;
          state_d = S_CHECK;
        end
      end
      S_CHECK: begin
        mem_addr = r_q;
        if (hit) begin
          state_d = S_DRAW;
        end else begin
          mem_we    = 1'b1;
          mem_wdata = s_q ? NEG : POS;
          wt_d      = wt_q + 1'b1;
          // wt_d is the post-write count
          state_d   = (wt_d == WTGT) ? S_DONE : S_DRAW;
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      lfsr_q  <= 32'h1;
      i_q     <= '0;
      r_q     <= '0;
      s_q     <= 1'b0;
      wt_q    <= '0;
    end else begin
      state_q <= state_d;
      lfsr_q  <= lfsr_d;
      i_q     <= i_d;
      r_q     <= r_d;
      s_q     <= s_d;
      wt_q    <= wt_d;
    end
  end

  assign busy   = (state_q == S_GEN)  || (state_q == S_CLEAR)
               || (state_q == S_DRAW) || (state_q == S_CHECK);
  assign done   = state_q == S_DONE;
  assign weight = wt_q;

endmodule

// File: tb/tb_short_poly_gen.sv
// tb_short_poly_gen: drives four differently-sized generators against
// a behavioural golden model and a write-first RAM per instance.
module tb_short_poly_gen;

  localparam int NI = 4;
  localparam int NT = 8;
  localparam int PP [NI] = '{757, 16, 4, 8};
  localparam int WW [NI] = '{286, 5, 4, 0};
  localparam int AA [NI] = '{11, 5, 3, 4};

  typedef struct {
    int          k;
    bit          md;
    logic [31:0] sd;
    int          nw;
    int          wt;
  } vec_t;

  logic clk = 1'b0;
  logic rst_n;
  logic [NI-1:0] start;
  logic mode;
  logic [31:0] seed;
  logic [NI-1:0] we, busy, done;
  logic [NI-1:0][10:0] addr, weight;
  logic [NI-1:0][12:0] wdata;

  int checks = 0;
  int errors = 0;
  int obs_a[$], obs_d[$], obs_c[$];
  int exp_a[$], exp_d[$];

  always #5 clk = ~clk;

  for (genvar g = 0; g < NI; g++) begin : g_dut
    localparam int AWG = AA[g];
    logic [AWG-1:0] a_l, wt_l;
    logic [12:0] rd_l;
    logic [12:0] mem [0:(1<<AWG)-1];

    short_poly_gen #(
      .P(PP[g]), .W(WW[g]), .Q(5167), .DW(13), .AW(AWG)
    ) u_dut (
      .clk(clk),
      .rst_n(rst_n),
      .start(start[g]),
      .mode(mode),
      .seed(seed),
      .mem_rdata(rd_l),
      .mem_addr(a_l),
      .mem_wdata(wdata[g]),
      .mem_we(we[g]),
      .busy(busy[g]),
      .done(done[g]),
      .weight(wt_l)
    );

    assign addr[g]   = 11'(a_l);
    assign weight[g] = 11'(wt_l);

    always @(posedge clk) begin
      if (we[g]) mem[a_l] <= wdata[g];
      rd_l <= we[g] ? wdata[g] : mem[a_l];
    end
  end

  task automatic chk(input string nm, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d want %0d", nm, act, exp);
    end
  endtask

  function automatic logic [31:0] step(input logic [31:0] l);
    return (l >> 1) ^ (l[0] ? 32'h8020_0003 : 32'h0);
  endfunction

  task automatic model(input int k, input bit md, input logic [31:0] sd,
                       output int cyc, output int wt);
    logic [31:0] l;
    int p, w, aw, i, r, d;
    int sh [2048];
    p = PP[k]; w = WW[k]; aw = AA[k];
    l = (sd == 0) ? 32'h1 : sd;
    exp_a.delete(); exp_d.delete();
    cyc = 0; wt = 0;
    if (!md) begin
      i = 0;
      while (i < p) begin
        cyc++;
        if (l[1:0] != 2'b11) begin
          d = (l[1:0] == 2'b00) ? 0 : (l[1:0] == 2'b01) ? 1 : 5166;
          exp_a.push_back(i); exp_d.push_back(d);
          if (d != 0) wt++;
          i++;
        end
        l = step(l);
      end
    end else begin
      for (int j = 0; j < p; j++) begin
        exp_a.push_back(j); exp_d.push_back(0);
        sh[j] = 0; cyc++;
      end
      while (wt < w) begin
        r = int'(l & ((32'h1 << aw) - 32'h1));
        d = l[aw] ? 5166 : 1;
        l = step(l);
        cyc++;
        if (r < p) begin
          cyc++;
          if (sh[r] == 0) begin
            sh[r] = d;
            exp_a.push_back(r); exp_d.push_back(d);
            wt++;
          end
        end
      end
    end
  endtask

  task automatic run(input int k, input bit md, input logic [31:0] sd,
                     input bit poke, output int cyc, output int wt);
    bit fin;
    obs_a.delete(); obs_d.delete(); obs_c.delete();
    cyc = 0; wt = 0; fin = 0;
    @(negedge clk);
    start[k] = 1'b1; mode = md; seed = sd;
    @(negedge clk);
    start[k] = 1'b0;
    for (int n = 0; n < 20000 && !fin; n++) begin
      if (done[k]) begin
        fin = 1;
        wt  = int'(weight[k]);
        chk("busy_in_done", int'(busy[k]), 0);
      end else begin
        if (busy[k]) cyc++;
        if (we[k]) begin
          obs_a.push_back(int'(addr[k]));
          obs_d.push_back(int'(wdata[k]));
          obs_c.push_back(cyc);
        end
        if (poke && cyc >= 2 && cyc < 5) begin
          start[k] = 1'b1; mode = ~md; seed = ~sd;
        end else begin
          start[k] = 1'b0; mode = md; seed = sd;
        end
        @(negedge clk);
      end
    end
    start[k] = 1'b0;
    if (!fin) chk("done_timeout", 0, 1);
    @(negedge clk);
    chk("done_pulse", int'(done[k]), 0);
    chk("idle_busy", int'(busy[k]), 0);
    chk("idle_we", int'(we[k]), 0);
  endtask

  task automatic verify(input int k, input bit md, input logic [31:0] sd,
                        input int nw, input int ewt, input int cyc,
                        input int wt, output int sg);
    int mc, mw, nz, n, cnt;
    model(k, md, sd, mc, mw);
    chk("nwrites", obs_a.size(), nw);
    chk("nwrites_model", obs_a.size(), exp_a.size());
    n = (obs_a.size() < exp_a.size()) ? obs_a.size() : exp_a.size();
    nz = 0; sg = 0;
    for (int j = 0; j < n; j++) begin
      chk("waddr", obs_a[j], exp_a[j]);
      chk("wdata", obs_d[j], exp_d[j]);
    end
    foreach (obs_a[j]) begin
      if (obs_d[j] != 0) nz++;
      sg = sg * 31 + obs_a[j] * 8192 + obs_d[j];
    end
    chk("cycles", cyc, mc);
    chk("weight", wt, mw);
    chk("weight_nz", wt, nz);
    if (ewt >= 0) chk("weight_tbl", wt, ewt);
    if (md && k == 2) begin
      for (int a = 0; a < PP[k]; a++) begin
        cnt = 0;
        foreach (obs_a[j]) if (obs_a[j] == a && obs_d[j] != 0) cnt++;
        chk("coll_once", cnt, 1);
      end
    end
  endtask

  initial begin
    vec_t tbl [NT];
    int cyc, wt;
    int sig [NT];
    int dummy;

    tbl[0] = '{0, 1'b0, 32'h0000_0001, 757,  -1};
    tbl[1] = '{0, 1'b0, 32'h0000_0000, 757,  -1};
    tbl[2] = '{1, 1'b1, 32'hDEAD_BEEF, 21,   5};
    tbl[3] = '{2, 1'b1, 32'h1234_5678, 8,    4};
    tbl[4] = '{3, 1'b1, 32'h0000_CAFE, 8,    0};
    tbl[5] = '{0, 1'b1, 32'h0BAD_F00D, 1043, 286};
    tbl[6] = '{1, 1'b0, 32'h0000_0055, 16,   -1};
    tbl[7] = '{3, 1'b0, 32'h0000_0000, 8,    -1};

    rst_n = 1'b0; start = '0; mode = 1'b0; seed = 32'h0;
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      start = ~start; mode = ~mode; seed = seed + 32'h1;
      for (int k = 0; k < NI; k++) begin
        chk("rst_we",     int'(we[k]),     0);
        chk("rst_busy",   int'(busy[k]),   0);
        chk("rst_done",   int'(done[k]),   0);
        chk("rst_addr",   int'(addr[k]),   0);
        chk("rst_wdata",  int'(wdata[k]),  0);
        chk("rst_weight", int'(weight[k]), 0);
      end
    end
    @(negedge clk);
    start = '0;
    rst_n = 1'b1;
    @(negedge clk);

    // seed 1: +1 @0, reject, -1 @1, +1 @2
    run(0, 1'b0, 32'h1, 1'b0, cyc, wt);
    chk("hand_n", int'(obs_a.size() >= 3), 1);
    chk("hand_c0", obs_c[0], 1);
    chk("hand_c1", obs_c[1], 3);
    chk("hand_c2", obs_c[2], 4);
    chk("hand_a0", obs_a[0], 0);
    chk("hand_d0", obs_d[0], 1);
    chk("hand_a1", obs_a[1], 1);
    chk("hand_d1", obs_d[1], 5166);
    chk("hand_a2", obs_a[2], 2);
    chk("hand_d2", obs_d[2], 1);

    for (int i = 0; i < NT; i++) begin
      run(tbl[i].k, tbl[i].md, tbl[i].sd, 1'b0, cyc, wt);
      verify(tbl[i].k, tbl[i].md, tbl[i].sd, tbl[i].nw, tbl[i].wt,
             cyc, wt, sig[i]);
    end
    chk("seed0_eq_seed1", sig[1], sig[0]);

    run(1, 1'b1, 32'hDEAD_BEEF, 1'b1, cyc, wt);
    verify(1, 1'b1, 32'hDEAD_BEEF, 21, 5, cyc, wt, dummy);

    @(negedge clk);
    start[1] = 1'b1; mode = 1'b1; seed = 32'h77;
    @(negedge clk);
    start[1] = 1'b0;
    repeat (4) @(negedge clk);
    chk("clr_we", int'(we[1]), 1);
    chk("clr_addr", int'(addr[1]), 4);
    #2 rst_n = 1'b0;
    #1;
    chk("arst_busy", int'(busy[1]), 0);
    chk("arst_we", int'(we[1]), 0);
    chk("arst_addr", int'(addr[1]), 0);
    chk("arst_weight", int'(weight[1]), 0);
    @(negedge clk);
    rst_n = 1'b1;
    run(1, 1'b1, 32'h000B_EEF0, 1'b0, cyc, wt);
    verify(1, 1'b1, 32'h000B_EEF0, 21, 5, cyc, wt, dummy);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
